// File: rtl/perceptron_bp_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package : bp_pkg
// Brief   : Shared types, derived widths and helpers for the perceptron BP.
// Rev     : 1.0  initial release
// ============================================================================
package bp_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_WRITE   = 2'd3
   } bp_state_t;

   function automatic int bp_idx_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit over the worst-case magnitude keeps the sum overflow-free.
   function automatic int bp_sum_w(input int hist_len, input int weight_w);
      return weight_w + $clog2(hist_len + 1) + 1;
   endfunction

   localparam int IDX_W = bp_idx_w(256);
   localparam int SUM_W = bp_sum_w(14, 8);

   function automatic int sat_inc(input int w, input logic up, input int weight_w);
      int w_max;
      int w_min;
      w_max = (1 << (weight_w - 1)) - 1;
      w_min = -(1 << (weight_w - 1));
      if (up)
         return (w >= w_max) ? w_max : w + 1;
      else
         return (w <= w_min) ? w_min : w - 1;
   endfunction

   function automatic logic [31:0] bp_fold(input logic [31:0] pc,
                                           input logic [31:0] ghr,
                                           input int          idx_w);
      logic [31:0] mask;
      mask = (32'd1 << idx_w) - 32'd1;
      return ((pc >> 2) ^ ghr) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_bp_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : perceptron_bp_gen_if
// Brief     : Fetch lookup, execute training handshake and status bundle.
// Rev       : 1.0  initial release
// ============================================================================
interface perceptron_bp_gen_if;
   logic [31:0] pc_f;
   logic        branch_en_f;
   logic        bp_valid;
   logic        bp_taken;
   logic [31:0] pc_ex;
   logic        branch_en_ex;
   logic        branch_taken_ex;
   logic        ex_ready;
   logic        init_done;
   logic [31:0] train_cnt;
   logic [31:0] mispred_cnt;

   modport master (
      output pc_f, branch_en_f, pc_ex, branch_en_ex, branch_taken_ex,
      input  bp_valid, bp_taken, ex_ready, init_done, train_cnt, mispred_cnt
   );

   modport slave (
      input  pc_f, branch_en_f, pc_ex, branch_en_ex, branch_taken_ex,
      output bp_valid, bp_taken, ex_ready, init_done, train_cnt, mispred_cnt
   );
endinterface
`default_nettype wire

// File: rtl/perceptron_bp_gen_dot.sv
`default_nettype none
// ============================================================================
// Module : perceptron_dot
// Brief  : Combinational bipolar dot product of one weight row with a history.
// Rev    : 1.0  initial release
// ============================================================================
module perceptron_dot
   import bp_pkg::*;
#(
   parameter  int HIST_LEN = 14,
   parameter  int WEIGHT_W = 8,
   localparam int C_SUM_W  = bp_sum_w(HIST_LEN, WEIGHT_W)
)(
   input  logic [(HIST_LEN+1)*WEIGHT_W-1:0] row,
   input  logic [HIST_LEN-1:0]              ghr,
   output logic signed [C_SUM_W-1:0]        y
);

   logic signed [C_SUM_W-1:0]  w_acc;
   logic signed [WEIGHT_W-1:0] w_wt;

   // w0 is the bias (x0 = +1); a clear history bit negates its weight.
   always_comb begin
      w_wt  = row[WEIGHT_W-1:0];
      w_acc = C_SUM_W'(w_wt);
      for (int i = 1; i <= HIST_LEN; i++) begin
         w_wt = row[i*WEIGHT_W +: WEIGHT_W];
         if (ghr[i-1])
            w_acc = w_acc + C_SUM_W'(w_wt);
         else
            w_acc = w_acc - C_SUM_W'(w_wt);
      end
   end

   assign y = w_acc;

endmodule
`default_nettype wire

// File: rtl/perceptron_bp_gen.sv
`default_nettype none
// ============================================================================
// Module : perceptron_bp_gen
// Brief  : Perceptron branch predictor: registered fetch lookup, 3-cycle trainer.
// Rev    : 1.0  initial release
// ============================================================================
module perceptron_bp_gen
   import bp_pkg::*;
#(
   parameter int HIST_LEN = 14,
   parameter int WEIGHT_W = 8,
   parameter int DEPTH    = 256,
   parameter int THETA    = 41
)(
   input  logic                clk,
   input  logic                rst,
   perceptron_bp_gen_if.slave  bus
);

   localparam int c_idx_w = bp_idx_w(DEPTH);
   localparam int c_sum_w = bp_sum_w(HIST_LEN, WEIGHT_W);
   localparam int c_row_w = (HIST_LEN + 1) * WEIGHT_W;
   localparam logic signed [c_sum_w-1:0] c_theta_pos = c_sum_w'(THETA);
   localparam logic signed [c_sum_w-1:0] c_theta_neg = -c_sum_w'(THETA);
   localparam logic signed [c_sum_w-1:0] c_sum_zero  = '0;

   bp_state_t              r_state;
   logic [c_row_w-1:0]     r_table [DEPTH];
   logic [HIST_LEN-1:0]    r_ghr;
   logic [HIST_LEN-1:0]    r_ghr_lat;
   logic [c_idx_w-1:0]     r_clr_idx;
   logic [c_idx_w-1:0]     r_idx;
   logic                   r_t;
   logic                   r_update;
   logic                   r_mis;
   logic [c_row_w-1:0]     r_new_row;
   logic                   r_bp_valid;
   logic                   r_bp_taken;
   logic                   r_ex_ready;
   logic                   r_init_done;
   logic [31:0]            r_train_cnt;
   logic [31:0]            r_mispred_cnt;

   logic [c_idx_w-1:0]        w_idx_f;
   logic [c_idx_w-1:0]        w_idx_ex;
   logic [c_row_w-1:0]        w_row_f;
   logic [c_row_w-1:0]        w_row_c;
   logic signed [c_sum_w-1:0] w_y_f;
   logic signed [c_sum_w-1:0] w_y_c;
   logic                      w_lookup;
   logic                      w_mis_c;
   logic                      w_upd_c;
   logic [c_row_w-1:0]        w_new_row;
   logic                      w_we;
   logic [c_idx_w-1:0]        w_wa;
   logic [c_row_w-1:0]        w_wd;

   assign w_idx_f  = c_idx_w'(bp_fold(bus.pc_f,  32'(r_ghr), c_idx_w));
   assign w_idx_ex = c_idx_w'(bp_fold(bus.pc_ex, 32'(r_ghr), c_idx_w));
   assign w_row_f  = r_table[w_idx_f];
   assign w_row_c  = r_table[r_idx];
   assign w_lookup = bus.branch_en_f && (r_state != ST_CLEAR);

   perceptron_dot #(.HIST_LEN(HIST_LEN), .WEIGHT_W(WEIGHT_W)) u_dot_f (
      .row (w_row_f),
      .ghr (r_ghr),
      .y   (w_y_f)
   );

   perceptron_dot #(.HIST_LEN(HIST_LEN), .WEIGHT_W(WEIGHT_W)) u_dot_c (
      .row (w_row_c),
      .ghr (r_ghr_lat),
      .y   (w_y_c)
   );

   assign w_mis_c = (w_y_c >= c_sum_zero) != r_t;
   assign w_upd_c = w_mis_c || ((w_y_c <= c_theta_pos) && (w_y_c >= c_theta_neg));

   assign w_new_row[WEIGHT_W-1:0] =
      WEIGHT_W'(sat_inc(int'($signed(w_row_c[WEIGHT_W-1:0])), r_t, WEIGHT_W));

   for (genvar gi = 1; gi <= HIST_LEN; gi++) begin : g_new_w
      assign w_new_row[gi*WEIGHT_W +: WEIGHT_W] =
         WEIGHT_W'(sat_inc(int'($signed(w_row_c[gi*WEIGHT_W +: WEIGHT_W])),
                           r_t == r_ghr_lat[gi-1], WEIGHT_W));
   end

   // Single write port shared by the sweeping clear and the trainer commit.
   assign w_we = (r_state == ST_CLEAR) || ((r_state == ST_WRITE) && r_update);
   assign w_wa = (r_state == ST_CLEAR) ? r_clr_idx : r_idx;
   assign w_wd = (r_state == ST_CLEAR) ? '0 : r_new_row;

   always_ff @(posedge clk) begin
      if (w_we)
         r_table[w_wa] <= w_wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_CLEAR;
         r_ghr         <= '0;
         r_ghr_lat     <= '0;
         r_clr_idx     <= '0;
         r_idx         <= '0;
         r_t           <= 1'b0;
         r_update      <= 1'b0;
         r_mis         <= 1'b0;
         r_new_row     <= '0;
         r_bp_valid    <= 1'b0;
         r_bp_taken    <= 1'b0;
         r_ex_ready    <= 1'b0;
         r_init_done   <= 1'b0;
         r_train_cnt   <= '0;
         r_mispred_cnt <= '0;
      end else begin
         r_bp_valid <= w_lookup;
         r_bp_taken <= w_lookup && (w_y_f >= c_sum_zero);
         case (r_state)
            ST_CLEAR: begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (r_clr_idx == c_idx_w'(DEPTH - 1)) begin
                  r_state     <= ST_IDLE;
                  r_ex_ready  <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            ST_IDLE: begin
               // Index and latched history use the GHR before this branch shifts in.
               if (bus.branch_en_ex) begin
                  r_idx      <= w_idx_ex;
                  r_ghr_lat  <= r_ghr;
                  r_t        <= bus.branch_taken_ex;
                  r_ghr      <= {r_ghr[HIST_LEN-2:0], bus.branch_taken_ex};
                  r_ex_ready <= 1'b0;
                  r_state    <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               r_new_row <= w_new_row;
               r_update  <= w_upd_c;
               r_mis     <= w_mis_c;
               r_state   <= ST_WRITE;
            end
            ST_WRITE: begin
               if (r_update)
                  r_train_cnt <= r_train_cnt + 32'd1;
               if (r_mis)
                  r_mispred_cnt <= r_mispred_cnt + 32'd1;
               r_ex_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

   assign bus.bp_valid    = r_bp_valid;
   assign bus.bp_taken    = r_bp_taken;
   assign bus.ex_ready    = r_ex_ready;
   assign bus.init_done   = r_init_done;
   assign bus.train_cnt   = r_train_cnt;
   assign bus.mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_bp_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_perceptron_bp_gen
// Brief  : Scoreboard bench: directed lookups/trainings on a default and a tiny DUT.
// Rev    : 1.0  initial release
// ============================================================================
module tb_perceptron_bp_gen;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   perceptron_bp_gen_if bif ();
   perceptron_bp_gen_if sif ();

   perceptron_bp_gen #(.HIST_LEN(14), .WEIGHT_W(8), .DEPTH(256), .THETA(41)) dut (
      .clk (clk), .rst (rst), .bus (bif)
   );

   // Narrow weights make |y| <= 40 <= THETA, so every training updates and saturates.
   perceptron_bp_gen #(.HIST_LEN(4), .WEIGHT_W(4), .DEPTH(16), .THETA(41)) dut_s (
      .clk (clk), .rst (rst), .bus (sif)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        exp_q[$];
   logic        mon_exp;
   logic [13:0] ghr_m;
   logic [3:0]  ghr_s;
   logic [7:0]  sel;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every valid prediction must match the oldest expectation.
   initial forever begin
      @(negedge clk);
      if (bif.bp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_bp_valid", bif.bp_valid, 1'b0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("bp_taken", bif.bp_taken, mon_exp);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready(input bit sm);
      int k = 0;
      while ((sm ? sif.ex_ready : bif.ex_ready) !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if ((sm ? sif.ex_ready : bif.ex_ready) !== 1'b1)
         check("ex_ready_timeout", sm ? sif.ex_ready : bif.ex_ready, 1'b1);
   endtask

   task automatic train(input bit sm, input logic [31:0] pc, input logic t);
      wait_ready(sm);
      if (sm) begin
         sif.pc_ex = pc; sif.branch_taken_ex = t; sif.branch_en_ex = 1'b1;
         ghr_s = {ghr_s[2:0], t};
      end else begin
         bif.pc_ex = pc; bif.branch_taken_ex = t; bif.branch_en_ex = 1'b1;
         ghr_m = {ghr_m[12:0], t};
      end
      @(negedge clk);
      bif.branch_en_ex = 1'b0;
      sif.branch_en_ex = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic exp);
      bif.pc_f = pc; bif.branch_en_f = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      bif.branch_en_f = 1'b0;
   endtask

   task automatic clear_phase(input string tag);
      repeat (255) @(posedge clk);
      #1;
      check({tag, "_ex_ready_255"},  bif.ex_ready,  1'b0);
      check({tag, "_init_done_255"}, bif.init_done, 1'b0);
      check({tag, "_bp_valid_clr"},  bif.bp_valid,  1'b0);
      bif.branch_en_f = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_ex_ready_256"},  bif.ex_ready,  1'b1);
      check({tag, "_init_done_256"}, bif.init_done, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bif.pc_f = '0; bif.branch_en_f = 1'b0; bif.pc_ex = '0;
      bif.branch_en_ex = 1'b0; bif.branch_taken_ex = 1'b0;
      sif.pc_f = '0; sif.branch_en_f = 1'b0; sif.pc_ex = '0;
      sif.branch_en_ex = 1'b0; sif.branch_taken_ex = 1'b0;
      ghr_m = '0; ghr_s = '0;
      repeat (3) @(negedge clk);
      check("rst_bp_valid",  bif.bp_valid,    1'b0);
      check("rst_bp_taken",  bif.bp_taken,    1'b0);
      check("rst_ex_ready",  bif.ex_ready,    1'b0);
      check("rst_init_done", bif.init_done,   1'b0);
      check("rst_train_cnt", bif.train_cnt,   32'd0);
      check("rst_mispred",   bif.mispred_cnt, 32'd0);
      check("rst_ghr",       dut.r_ghr,       14'd0);

      // Lookups held high through the clear must never produce a valid prediction.
      rst = 1'b0;
      bif.pc_f = 32'h100; bif.branch_en_f = 1'b1;
      clear_phase("init");
      lookup(32'h100, 1'b1);

      train(1'b0, 32'h100, 1'b1);
      wait_ready(1'b0);
      check("row40_after_first", dut.r_table[8'h40], {{14{8'hFF}}, 8'h01});
      check("ghr_after_first",   dut.r_ghr,          14'h0001);
      check("train_cnt_first",   bif.train_cnt,      32'd1);
      check("mispred_first",     bif.mispred_cnt,    32'd0);

      // Fill the GHR with ones, each training landing in its own fresh row 0x10+k.
      for (int k = 1; k <= 13; k++) begin
         sel = (8'h10 + 8'(k)) ^ ghr_m[7:0];
         train(1'b0, {22'd0, sel, 2'b00}, 1'b1);
      end
      wait_ready(1'b0);
      check("ghr_all_ones",     dut.r_ghr,       14'h3FFF);
      check("train_cnt_fill",   bif.train_cnt,   32'd14);

      // Row 0xBF: y goes 0, 15, 30, 45 -> three updates, then above threshold.
      for (int k = 0; k < 64; k++) train(1'b0, 32'h100, 1'b1);
      wait_ready(1'b0);
      check("train_cnt_theta",  bif.train_cnt,     32'd17);
      check("mispred_theta",    bif.mispred_cnt,   32'd0);
      check("rowBF_weights",    dut.r_table[8'hBF], {15{8'h03}});
      lookup(32'h100, 1'b1);

      // Held request: transfers only at cycles 0, 3 and 6 (rows 0x7F, 0x7E, 0x7C).
      bif.pc_ex = 32'h200; bif.branch_taken_ex = 1'b0; bif.branch_en_ex = 1'b1;
      repeat (7) @(negedge clk);
      bif.branch_en_ex = 1'b0;
      ghr_m = {ghr_m[10:0], 3'b000};
      wait_ready(1'b0);
      check("ghr_hold_3_shifts", dut.r_ghr,       ghr_m);
      check("train_cnt_hold",    bif.train_cnt,   32'd20);
      check("mispred_hold",      bif.mispred_cnt, 32'd3);

      // Lookup of row 0x20 during its WRITE sees old weights (y=0), next cycle y=-13.
      bif.pc_ex = 32'h360; bif.branch_taken_ex = 1'b0; bif.branch_en_ex = 1'b1;
      @(negedge clk);
      bif.branch_en_ex = 1'b0;
      ghr_m = {ghr_m[12:0], 1'b0};
      @(negedge clk);
      bif.pc_f = 32'h340; bif.branch_en_f = 1'b1; exp_q.push_back(1'b1);
      @(negedge clk);
      exp_q.push_back(1'b0);
      @(negedge clk);
      bif.branch_en_f = 1'b0;
      wait_ready(1'b0);
      check("train_cnt_rbw", bif.train_cnt,   32'd21);
      check("mispred_rbw",   bif.mispred_cnt, 32'd4);

      // Reset during COMPUTE: pending update dropped, full clear repeats.
      train(1'b0, 32'h100, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst_train_cnt", bif.train_cnt,   32'd0);
      check("midrst_mispred",   bif.mispred_cnt, 32'd0);
      check("midrst_ex_ready",  bif.ex_ready,    1'b0);
      check("midrst_init_done", bif.init_done,   1'b0);
      check("midrst_ghr",       dut.r_ghr,       14'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_phase("reclear");
      check("row40_cleared", dut.r_table[8'h40], 120'd0);
      lookup(32'h100, 1'b1);

      // Small DUT, row 5 forced: saturate to +7 then drive the bias to -8.
      ghr_s = '0;
      wait_ready(1'b1);
      for (int k = 0; k < 24; k++) train(1'b1, {26'd0, 4'h5 ^ ghr_s, 2'b00}, 1'b1);
      for (int k = 0; k < 24; k++) train(1'b1, {26'd0, 4'h5 ^ ghr_s, 2'b00}, 1'b0);
      wait_ready(1'b1);
      check("small_row_saturated", dut_s.r_table[5], 20'h77778);
      check("small_train_cnt",     sif.train_cnt,    32'd48);
      for (int k = 0; k < 300; k++) train(1'b1, {26'd0, 4'h5 ^ ghr_s, 2'b00}, 1'(k));
      wait_ready(1'b1);
      check("small_train_cnt_alt", sif.train_cnt,    32'd348);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
